ad1939_i2s_rx: RTL and testbench

- Deserialises one AD1939 ADC serial data line (ASDATA) into parallel stereo samples. It uses the codec's ABCLK/ALRCLK, both oversampled in the fabric system clock domain.
- Sits directly upstream of the audio Avalon-ST sink inside som_system: pins in, channelised samples out.
- Two instances cover asdata1 and asdata2.

---
 rtl/ad1939_i2s_rx_pkg.sv | 20 ++
 rtl/ad1939_i2s_rx_sync_edge_det.sv | 32 +++
 rtl/ad1939_i2s_rx.sv | 137 +++++++++++++
 tb/tb_ad1939_i2s_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ad1939_i2s_rx_pkg.sv
// Shared types and constants for the AD1939 ADC serial receiver.
package ad1939_pkg;

  localparam int unsigned DATA_W_DEFAULT = 24;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } rx_state_t;

  // Slot position counts 0..DATA_W+SLOT_DELAY inclusive.
  function automatic int unsigned pos_width(input int unsigned data_w,
                                            input int unsigned slot_delay);
    return $clog2(data_w + slot_delay + 1);
  endfunction

endpackage

// File: rtl/ad1939_i2s_rx_sync_edge_det.sv
// Multi-flop synchroniser for one async input, with an optional one-clk
// pulse on each rising edge of the synchronised level.
module sync_edge_det #(
  parameter int unsigned STAGES   = 2,
  parameter bit          EDGE_DET = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] chain;
  logic         prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[N-2:0], d};
      prev  <= chain[N-1];
    end
  end

  assign q    = chain[N-1];
  assign rise = EDGE_DET ? (chain[N-1] & ~prev) : 1'b0;

endmodule

// File: rtl/ad1939_i2s_rx.sv
// AD1939 ADC serial-data deserialiser: oversamples ABCLK/ALRCLK/ASDATA in the
// system clock domain and emits one parallel sample per completed slot.
module ad1939_i2s_rx
  import ad1939_pkg::*;
#(
  parameter int unsigned DATA_W        = DATA_W_DEFAULT,
  parameter int unsigned SLOT_DELAY    = 1,
  parameter bit          LEFT_LR_LEVEL = 1'b0,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_in,
  input  logic              abclk_in,
  input  logic              alrclk_in,
  input  logic              asdata_in,
  output logic [DATA_W-1:0] data_out,
  output logic              channel_out,
  output logic              valid_out,
  output logic              error_out,
  input  logic              error_clear_in
);

  localparam int unsigned      POS_W    = pos_width(DATA_W, SLOT_DELAY);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(DATA_W + SLOT_DELAY);
  localparam logic [POS_W-1:0] FIRST    = POS_W'(SLOT_DELAY);
  localparam logic [POS_W-1:0] SPAN     = POS_W'(DATA_W);
  localparam logic [POS_W-1:0] LAST_REL = POS_W'(DATA_W - 1);

  logic bclk_rise, bclk_level;
  logic lr, lr_rise;
  logic sd, sd_rise;
  logic unused_sync;

  sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_bclk_sync (
    .clk(clk), .reset(reset), .d(abclk_in), .q(bclk_level), .rise(bclk_rise)
  );
  sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_lr_sync (
    .clk(clk), .reset(reset), .d(alrclk_in), .q(lr), .rise(lr_rise)
  );
  sync_edge_det #(.STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_sd_sync (
    .clk(clk), .reset(reset), .d(asdata_in), .q(sd), .rise(sd_rise)
  );

  assign unused_sync = bclk_level | lr_rise | sd_rise;

  rx_state_t         state, state_next;
  logic              lr_prev;
  logic              primed;
  logic              slot_ch;
  logic              slot_full;
  logic              pend;
  logic [POS_W-1:0]  pos, eff, rel;
  logic [DATA_W-1:0] shreg;
  logic              slot_start, capture, last_bit, short_slot;

  // The first BCLK rise after reset only primes lr_prev; otherwise a reset
  // released inside a right slot would look like a slot start mid-word.
  always_comb begin
    slot_start = bclk_rise && primed && (lr != lr_prev);
    if (slot_start)          eff = '0;
    else if (pos == POS_MAX) eff = POS_MAX;
    else                     eff = pos + POS_W'(1);
    rel = eff - FIRST;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= UNLOCKED;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    last_bit   = 1'b0;
    short_slot = 1'b0;
    if (!enable_in) begin
      state_next = UNLOCKED;
    end else begin
      if (state == UNLOCKED && slot_start) state_next = LOCKED;
      if (bclk_rise && state_next == LOCKED && rel < SPAN) begin
        capture  = 1'b1;
        last_bit = (rel == LAST_REL);
      end
      short_slot = slot_start && (state == LOCKED) && !slot_full;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lr_prev     <= LEFT_LR_LEVEL;
      primed      <= 1'b0;
      pos         <= '0;
      shreg       <= '0;
      slot_ch     <= CH_LEFT;
      slot_full   <= 1'b0;
      pend        <= 1'b0;
      data_out    <= '0;
      channel_out <= CH_LEFT;
      valid_out   <= 1'b0;
      error_out   <= 1'b0;
    end else begin
      pend      <= 1'b0;
      valid_out <= 1'b0;
      if (bclk_rise) begin
        lr_prev <= lr;
        primed  <= 1'b1;
      end
      if (!enable_in) begin
        pos       <= '0;
        shreg     <= '0;
        slot_full <= 1'b0;
      end else begin
        if (bclk_rise) begin
          pos <= eff;
          if (slot_start) begin
            slot_ch   <= (lr != LEFT_LR_LEVEL) ? CH_RIGHT : CH_LEFT;
            slot_full <= 1'b0;
          end
          if (capture) shreg <= {shreg[DATA_W-2:0], sd};
          if (last_bit) begin
            slot_full <= 1'b1;
            pend      <= 1'b1;
          end
        end
        if (pend) begin
          data_out    <= shreg;
          channel_out <= slot_ch;
          valid_out   <= 1'b1;
        end
      end
      if (error_clear_in)  error_out <= 1'b0;
      else if (short_slot) error_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ad1939_i2s_rx.sv
// Scoreboard bench for ad1939_i2s_rx: an I2S instance plus two instances fed a
// left-justified stream with left = LRCLK high.
module tb_ad1939_i2s_rx;
  import ad1939_pkg::*;

  localparam int HALF = 16;

  typedef enum int {H_NONE, H_RELEASE, H_ENABLE, H_LATENCY, H_CLEAR} hook_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, enable = 1'b1, error_clear = 1'b0;
  logic bclk = 1'b0, lr = 1'b1, sdata = 1'b0, lj_sel = 1'b0;

  logic m_bclk, m_lr, m_sd, j_bclk, j_lr, j_sd;
  assign m_bclk = bclk & ~lj_sel;
  assign m_lr   = lj_sel ? 1'b1 : lr;
  assign m_sd   = sdata & ~lj_sel;
  assign j_bclk = bclk & lj_sel;
  assign j_lr   = lj_sel ? lr : 1'b0;
  assign j_sd   = sdata & lj_sel;

  logic [23:0] m_data, lj_data, s1_data;
  logic        m_ch, m_valid, m_err;
  logic        lj_ch, lj_valid, lj_err;
  logic        s1_ch, s1_valid, s1_err;

  ad1939_i2s_rx #(.DATA_W(24), .SLOT_DELAY(1), .LEFT_LR_LEVEL(1'b0), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .enable_in(enable),
    .abclk_in(m_bclk), .alrclk_in(m_lr), .asdata_in(m_sd),
    .data_out(m_data), .channel_out(m_ch), .valid_out(m_valid),
    .error_out(m_err), .error_clear_in(error_clear)
  );

  ad1939_i2s_rx #(.DATA_W(24), .SLOT_DELAY(0), .LEFT_LR_LEVEL(1'b1), .SYNC_STAGES(2)) dut_lj (
    .clk(clk), .reset(reset), .enable_in(enable),
    .abclk_in(j_bclk), .alrclk_in(j_lr), .asdata_in(j_sd),
    .data_out(lj_data), .channel_out(lj_ch), .valid_out(lj_valid),
    .error_out(lj_err), .error_clear_in(error_clear)
  );

  ad1939_i2s_rx #(.DATA_W(24), .SLOT_DELAY(1), .LEFT_LR_LEVEL(1'b1), .SYNC_STAGES(2)) dut_sd1 (
    .clk(clk), .reset(reset), .enable_in(enable),
    .abclk_in(j_bclk), .alrclk_in(j_lr), .asdata_in(j_sd),
    .data_out(s1_data), .channel_out(s1_ch), .valid_out(s1_valid),
    .error_out(s1_err), .error_clear_in(error_clear)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [24:0] q_main[$];
  logic [24:0] q_lj[$];
  logic [24:0] q_sd1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon_main
    logic [24:0] e;
    if (m_valid) begin
      check("main_pending", 32'(q_main.size() != 0), 32'd1);
      if (q_main.size() != 0) begin
        e = q_main.pop_front();
        check("main_sample", 32'({m_ch, m_data}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : mon_lj
    logic [24:0] e;
    if (lj_valid) begin
      check("lj_pending", 32'(q_lj.size() != 0), 32'd1);
      if (q_lj.size() != 0) begin
        e = q_lj.pop_front();
        check("lj_sample", 32'({lj_ch, lj_data}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : mon_sd1
    logic [24:0] e;
    if (s1_valid) begin
      check("sd1_pending", 32'(q_sd1.size() != 0), 32'd1);
      if (q_sd1.size() != 0) begin
        e = q_sd1.pop_front();
        check("sd1_sample", 32'({s1_ch, s1_data}), 32'(e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a BCLK pin rise that was driven just after a clk edge.
  task automatic do_hook(input hook_t hook);
    case (hook)
      H_RELEASE: reset = 1'b0;
      H_ENABLE:  enable = 1'b1;
      H_LATENCY: begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("latency_early", 32'(m_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("latency_valid", 32'(m_valid), 32'd1);
      end
      H_CLEAR: begin
        repeat (2) @(posedge clk);
        #1 error_clear = 1'b1;
        @(posedge clk);
        #1 error_clear = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic send_slot(input logic lv, input logic [23:0] s, input int nbits,
                           input int delay, input int hook_bit = -1,
                           input hook_t hook = H_NONE);
    logic [23:0] sh;
    sh = s;
    for (int p = 0; p < nbits; p++) begin
      bclk = 1'b0;
      lr   = lv;
      if (p >= delay && p < delay + 24) begin
        sdata = sh[23];
        sh    = sh << 1;
      end else begin
        sdata = 1'b0;
      end
      tick(HALF);
      bclk = 1'b1;
      if (p == hook_bit) do_hook(hook);
      tick(HALF);
    end
  endtask

  task automatic i2s_frame(input logic [23:0] l, input logic [23:0] r, input bit expect_out);
    if (expect_out) begin
      q_main.push_back({CH_LEFT, l});
      q_main.push_back({CH_RIGHT, r});
    end
    send_slot(1'b0, l, 32, 1);
    send_slot(1'b1, r, 32, 1);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [23:0] l, r, ls;
    tick(4);
    check("reset_valid", 32'(m_valid), 32'd0);
    check("reset_err", 32'(m_err), 32'd0);
    check("reset_data", 32'(m_data), 32'd0);
    reset = 1'b0;
    tick(2);

    // Plain I2S frames, with the pin-to-valid latency measured on the first.
    send_slot(1'b1, 24'h0, 4, 1);
    q_main.push_back({CH_LEFT, 24'h7FFFFF});
    q_main.push_back({CH_RIGHT, 24'h800001});
    send_slot(1'b0, 24'h7FFFFF, 32, 1, 24, H_LATENCY);
    send_slot(1'b1, 24'h800001, 32, 1);
    for (int f = 0; f < 2; f++) i2s_frame(24'h7FFFFF, 24'h800001, 1'b1);
    check("basic_err", 32'(m_err), 32'd0);

    // Reset held through a left slot, released inside the right slot.
    reset = 1'b1;
    tick(4);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_ch", 32'(m_ch), 32'(CH_LEFT));
    check("rst_valid", 32'(m_valid), 32'd0);
    send_slot(1'b0, 24'h111111, 32, 1);
    send_slot(1'b1, 24'h222222, 32, 1, 10, H_RELEASE);
    for (int f = 0; f < 2; f++) i2s_frame(24'h3C0F81 + 24'(f), 24'hC3F07E - 24'(f), 1'b1);
    check("rst_err", 32'(m_err), 32'd0);

    // Short left slot: nothing emitted for it, sticky error, right slot intact.
    q_main.push_back({CH_RIGHT, 24'h0F0F0F});
    send_slot(1'b0, 24'hABCDEF, 16, 1);
    send_slot(1'b1, 24'h0F0F0F, 32, 1);
    check("short_err_set", 32'(m_err), 32'd1);
    i2s_frame(24'h000001, 24'hFFFFFF, 1'b1);
    check("short_err_sticky", 32'(m_err), 32'd1);
    error_clear = 1'b1;
    tick(1);
    error_clear = 1'b0;
    tick(1);
    check("short_err_cleared", 32'(m_err), 32'd0);

    // Clear asserted in the exact cycle the short slot is detected.
    q_main.push_back({CH_RIGHT, 24'h765432});
    send_slot(1'b0, 24'h13579B, 16, 1);
    send_slot(1'b1, 24'h765432, 32, 1, 0, H_CLEAR);
    check("clear_priority", 32'(m_err), 32'd0);

    // Disabled for three frames, re-enabled inside a left slot.
    enable = 1'b0;
    for (int f = 0; f < 3; f++) i2s_frame(24'h5A5A00 + 24'(f), 24'hA5A500 + 24'(f), 1'b0);
    q_main.push_back({CH_RIGHT, 24'h5DEECE});
    send_slot(1'b0, 24'h9ABCDE, 32, 1, 8, H_ENABLE);
    send_slot(1'b1, 24'h5DEECE, 32, 1);
    i2s_frame(24'h400000, 24'hBFFFFF, 1'b1);
    check("enable_err", 32'(m_err), 32'd0);

    // Left-justified stream with left = LRCLK high into SD=0 and SD=1 instances.
    bclk = 1'b0;
    lr   = 1'b0;
    tick(2);
    lj_sel = 1'b1;
    tick(2);
    send_slot(1'b0, 24'h0, 4, 0);
    for (int f = 0; f < 2; f++) begin
      l = (f == 0) ? 24'h123456 : 24'h800000;
      r = (f == 0) ? 24'hABCDEF : 24'h7FFFFF;
      q_lj.push_back({CH_LEFT, l});
      q_lj.push_back({CH_RIGHT, r});
      ls = l << 1;
      q_sd1.push_back({CH_LEFT, ls});
      ls = r << 1;
      q_sd1.push_back({CH_RIGHT, ls});
      send_slot(1'b1, l, 32, 0);
      send_slot(1'b0, r, 32, 0);
    end
    tick(20);
    check("lj_err", 32'(lj_err), 32'd0);
    check("sd1_err", 32'(s1_err), 32'd0);

    check("main_drain", 32'(q_main.size()), 32'd0);
    check("lj_drain", 32'(q_lj.size()), 32'd0);
    check("sd1_drain", 32'(q_sd1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
